ysyx_24090003_imm_stage: RTL

Parametrised, registered immediate-extraction stage between IFU and EXU. It accepts an instruction and its PC over a valid/ready handshake, classifies the instruction format, and produces the sign- or zero-extended immediate at XLEN width. It also produces the precomputed PC-relative target `pc + imm`. A 2-entry skid buffer sustains one instruction per cycle under backpressure, and a synchronous flush supports branch redirects.

---
 rtl/ysyx_24090003_imm_stage.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/ysyx_24090003_imm_stage.sv
// Immediate-extraction stage: classifies the instruction format, builds the XLEN-wide
// immediate and pc+imm target, and holds results in a 2-entry skid FIFO toward the EXU.
module ysyx_24090003_imm_stage #(
  parameter int XLEN        = 32,
  parameter bit ENABLE_ZIMM = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_itype,
  output logic [XLEN-1:0] out_target
);

  localparam logic [2:0] IT_NONE = 3'd0;
  localparam logic [2:0] IT_I    = 3'd1;
  localparam logic [2:0] IT_S    = 3'd2;
  localparam logic [2:0] IT_B    = 3'd3;
  localparam logic [2:0] IT_U    = 3'd4;
  localparam logic [2:0] IT_J    = 3'd5;
  localparam logic [2:0] IT_Z    = 3'd6;

  function automatic logic [2:0] classify(input logic [31:0] inst);
    logic [2:0] t;
    t = IT_NONE;
    case (inst[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: t = IT_I;
      7'b0011011: t = (XLEN == 64) ? IT_I : IT_NONE;
      7'b1110011: t = (inst[14] && ENABLE_ZIMM) ? IT_Z : IT_I;
      7'b0100011: t = IT_S;
      7'b1100011: t = IT_B;
      7'b0110111, 7'b0010111: t = IT_U;
      7'b1101111: t = IT_J;
      default:    t = IT_NONE;
    endcase
    return t;
  endfunction

  // Signed intermediates make the XLEN size cast perform the sign extension.
  function automatic logic [XLEN-1:0] extractImm(input logic [31:0] inst,
                                                 input logic [2:0]  itype);
    logic signed [11:0] immI;
    logic signed [11:0] immS;
    logic signed [12:0] immB;
    logic signed [31:0] immU;
    logic signed [20:0] immJ;
    logic [XLEN-1:0]    r;
    immI = inst[31:20];
    immS = {inst[31:25], inst[11:7]};
    immB = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    immU = {inst[31:12], 12'b0};
    immJ = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    r = '0;
    case (itype)
      IT_I:    r = XLEN'(immI);
      IT_S:    r = XLEN'(immS);
      IT_B:    r = XLEN'(immB);
      IT_U:    r = XLEN'(immU);
      IT_J:    r = XLEN'(immJ);
      IT_Z:    r = XLEN'(inst[19:15]);
      default: r = '0;
    endcase
    return r;
  endfunction

  // Stage p0: combinational decode and target add ahead of the buffer write
  logic [2:0]      itype_p0;
  logic [XLEN-1:0] imm_p0;
  logic [XLEN-1:0] target_p0;

  always_comb begin
    itype_p0  = classify(in_inst);
    imm_p0    = extractImm(in_inst, itype_p0);
    target_p0 = in_pc + imm_p0;
  end

  // Stage p1: 2-entry FIFO storage
  logic [31:0]     instBuf   [0:1];
  logic [XLEN-1:0] pcBuf     [0:1];
  logic [XLEN-1:0] immBuf    [0:1];
  logic [2:0]      itypeBuf  [0:1];
  logic [XLEN-1:0] targetBuf [0:1];
  logic            headPtr;
  logic            tailPtr;
  logic [1:0]      count;
  logic            doPush;
  logic            doPop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign doPush    = in_valid & in_ready;
  assign doPop     = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      headPtr <= 1'b0;
      tailPtr <= 1'b0;
      count   <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        instBuf[i]   <= '0;
        pcBuf[i]     <= '0;
        immBuf[i]    <= '0;
        itypeBuf[i]  <= IT_NONE;
        targetBuf[i] <= '0;
      end
    end else if (flush) begin
      headPtr <= 1'b0;
      tailPtr <= 1'b0;
      count   <= 2'd0;
    end else begin
      if (doPush) begin
        instBuf[tailPtr]   <= in_inst;
        pcBuf[tailPtr]     <= in_pc;
        immBuf[tailPtr]    <= imm_p0;
        itypeBuf[tailPtr]  <= itype_p0;
        targetBuf[tailPtr] <= target_p0;
        tailPtr            <= ~tailPtr;
      end
      if (doPop) begin
        headPtr <= ~headPtr;
      end
      case ({doPush, doPop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Output: head entry, forced to zero while the buffer is empty
  always_comb begin
    out_inst   = '0;
    out_pc     = '0;
    out_imm    = '0;
    out_itype  = IT_NONE;
    out_target = '0;
    if (out_valid) begin
      out_inst   = instBuf[headPtr];
      out_pc     = pcBuf[headPtr];
      out_imm    = immBuf[headPtr];
      out_itype  = itypeBuf[headPtr];
      out_target = targetBuf[headPtr];
    end
  end

endmodule
